// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters,
// with a one-entry registered response buffer tagged by requester id.
module alu_arbiter #(
  parameter int WIDTH     = 32,
  parameter bit PRIO_INIT = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [3:0]       req0_ctrl,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [3:0]       req1_ctrl,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic [WIDTH-1:0] alu_in1,
  output logic [WIDTH-1:0] alu_in2,
  output logic [3:0]       alu_control,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_zero,
  output logic             rsp_err
);

  localparam logic [3:0] CTRL_AND = 4'b0000;
  localparam logic [3:0] CTRL_OR  = 4'b0001;
  localparam logic [3:0] CTRL_ADD = 4'b0010;
  localparam logic [3:0] CTRL_SUB = 4'b0110;
  localparam logic [3:0] CTRL_SLT = 4'b0111;
  localparam logic [3:0] CTRL_NOR = 4'b1100;

  logic prio;
  logic can_accept;
  logic any_valid;
  logic grant;
  logic accept;
  logic ctrl_ok;

  // Readiness is gated by rst_n so no handshake is advertised during reset.
  always_comb begin
    can_accept = rst_n && (!rsp_valid || rsp_ready);
    any_valid  = req0_valid || req1_valid;
    grant      = (req0_valid && req1_valid) ? prio : req1_valid;
    accept     = can_accept && any_valid;
  end

  assign req0_ready = accept && !grant;
  assign req1_ready = accept && grant;

  // Idle the ALU at an add of zeros whenever nothing is being accepted.
  always_comb begin
    alu_in1     = '0;
    alu_in2     = '0;
    alu_control = CTRL_ADD;
    if (accept) begin
      alu_in1     = grant ? req1_a : req0_a;
      alu_in2     = grant ? req1_b : req0_b;
      alu_control = grant ? req1_ctrl : req0_ctrl;
    end
  end

  always_comb begin
    case (alu_control)
      CTRL_AND, CTRL_OR, CTRL_ADD, CTRL_SUB, CTRL_SLT, CTRL_NOR: ctrl_ok = 1'b1;
      default:                                                   ctrl_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_data  <= '0;
      rsp_zero  <= 1'b0;
      rsp_err   <= 1'b0;
      prio      <= PRIO_INIT;
    end else if (accept) begin
      rsp_valid <= 1'b1;
      rsp_id    <= grant;
      prio      <= ~grant;
      if (ctrl_ok) begin
        rsp_data <= alu_out;
        rsp_zero <= alu_zero;
        rsp_err  <= 1'b0;
      end else begin
        // Unsupported code: never forward whatever the ALU happens to output.
        rsp_data <= '0;
        rsp_zero <= 1'b1;
        rsp_err  <= 1'b1;
      end
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: a behavioural ALU drives alu_out, a
// reference model predicts grants and responses, a monitor checks the buffer.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [3:0]  req0_ctrl, req1_ctrl;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [31:0] alu_in1, alu_in2, alu_out;
  logic [3:0]  alu_control;
  logic        alu_zero;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_err;
  logic [31:0] rsp_data;

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(32), .PRIO_INIT(1'b0)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_ctrl(req0_ctrl),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_ctrl(req1_ctrl),
    .req1_a(req1_a), .req1_b(req1_b),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_control(alu_control),
    .alu_out(alu_out), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_zero(rsp_zero), .rsp_err(rsp_err)
  );

  // Behavioural ALU; unsupported codes yield junk so leaks would be visible.
  always_comb begin
    case (alu_control)
      4'b0000: alu_out = alu_in1 & alu_in2;
      4'b0001: alu_out = alu_in1 | alu_in2;
      4'b0010: alu_out = alu_in1 + alu_in2;
      4'b0110: alu_out = alu_in1 - alu_in2;
      4'b0111: alu_out = (alu_in1 < alu_in2) ? 32'd1 : 32'd0;
      4'b1100: alu_out = ~(alu_in1 | alu_in2);
      default: alu_out = 32'hDEAD_BEEF;
    endcase
    alu_zero = (alu_out == 32'd0);
  end

  typedef struct {
    logic        id;
    logic [31:0] data;
    logic        zero;
    logic        err;
  } rsp_t;

  rsp_t q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  logic m_valid, m_prio, last_acc0, last_acc1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic rsp_t ref_rsp(input logic id, input logic [3:0] c,
                                   input logic [31:0] a, input logic [31:0] b);
    rsp_t r;
    r.id  = id;
    r.err = 1'b0;
    case (c)
      4'd0:    r.data = a & b;
      4'd1:    r.data = a | b;
      4'd2:    r.data = a + b;
      4'd6:    r.data = a - b;
      4'd7:    r.data = (a < b) ? 32'd1 : 32'd0;
      4'd12:   r.data = ~(a | b);
      default: begin r.data = 32'd0; r.err = 1'b1; end
    endcase
    r.zero = (r.data == 32'd0);
    return r;
  endfunction

  // Monitor: each response is consumed exactly once, when rsp_ready is high.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && rsp_valid && rsp_ready) begin
        if (q.size() == 0) begin
          chk("rsp_unexpected", 32'd1, 32'd0);
        end else begin
          rsp_t e;
          e = q.pop_front();
          chk("rsp_id", {31'd0, rsp_id}, {31'd0, e.id});
          chk("rsp_data", rsp_data, e.data);
          chk("rsp_zero", {31'd0, rsp_zero}, {31'd0, e.zero});
          chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
        end
      end
    end
  end

  task automatic cycle(input logic v0, input logic [3:0] c0, input logic [31:0] a0, input logic [31:0] b0,
                       input logic v1, input logic [3:0] c1, input logic [31:0] a1, input logic [31:0] b1,
                       input logic rr);
    logic can, g, any;
    rsp_t e;
    @(posedge clk);
    #1;
    req0_valid = v0; req0_ctrl = c0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_ctrl = c1; req1_a = a1; req1_b = b1;
    rsp_ready  = rr;
    @(negedge clk);
    chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, m_valid});
    can = !m_valid || rr;
    any = can && (v0 || v1);
    g   = (v0 && v1) ? m_prio : v1;
    chk("req0_ready", {31'd0, req0_ready}, {31'd0, any && !g});
    chk("req1_ready", {31'd0, req1_ready}, {31'd0, any && g});
    last_acc0 = any && !g;
    last_acc1 = any && g;
    if (any) begin
      chk("alu_control", {28'd0, alu_control}, {28'd0, g ? c1 : c0});
      chk("alu_in1", alu_in1, g ? a1 : a0);
      e = g ? ref_rsp(1'b1, c1, a1, b1) : ref_rsp(1'b0, c0, a0, b0);
      q.push_back(e);
      m_prio  = !g;
      m_valid = 1'b1;
    end else begin
      chk("alu_idle_ctrl", {28'd0, alu_control}, 32'd2);
      chk("alu_idle_in", alu_in1 | alu_in2, 32'd0);
      if (rr) m_valid = 1'b0;
    end
  endtask

  task automatic idle(input logic rr);
    cycle(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0, rr);
  endtask

  task automatic check_cleared();
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_id", {31'd0, rsp_id}, 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_rsp_zero", {31'd0, rsp_zero}, 32'd0);
    chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
  endtask

  // Reset pulse between clock edges; requesters are valid during the pulse.
  task automatic pulse_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
    #1;
    check_cleared();
    chk("rst_ready0", {31'd0, req0_ready}, 32'd0);
    chk("rst_ready1", {31'd0, req1_ready}, 32'd0);
    q.delete();
    m_valid = 1'b0;
    m_prio  = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic        p0, p1, v0, v1, rr;
    logic [3:0]  c0, c1;
    logic [31:0] a0, b0, a1, b1;
    logic [3:0]  codes [8];
    codes = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12, 4'd3, 4'd2};
    rst_n = 1'b0;
    req0_valid = 1'b0; req0_ctrl = 4'd0; req0_a = '0; req0_b = '0;
    req1_valid = 1'b0; req1_ctrl = 4'd0; req1_a = '0; req1_b = '0;
    rsp_ready = 1'b0;
    m_valid = 1'b0; m_prio = 1'b0; last_acc0 = 1'b0; last_acc1 = 1'b0;
    #12;
    check_cleared();
    rst_n = 1'b1;

    // Single request
    cycle(1'b1, 4'b0010, 32'd5, 32'd7, 1'b0, 4'd0, 32'd0, 32'd0, 1'b1);
    idle(1'b1);
    chk("single_data", rsp_data, 32'd12);
    idle(1'b1);

    // Contention from a fresh priority pointer: 0,1,0,1
    pulse_reset();
    for (int i = 0; i < 4; i++)
      cycle(1'b1, 4'b0110, 32'd9, 32'd9, 1'b1, 4'b0001, 32'hF0, 32'h0F, 1'b1);
    idle(1'b1);

    // Backpressure: nor result held while req0 waits
    cycle(1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 4'b1100, 32'd0, 32'd0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 4'b0010, 32'd3, 32'd4, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
      chk("stall_data", rsp_data, 32'hFFFF_FFFF);
    end
    cycle(1'b1, 4'b0010, 32'd3, 32'd4, 1'b0, 4'd0, 32'd0, 32'd0, 1'b1);
    idle(1'b1);

    // Unsupported code, then contention shows prio advanced to 0
    cycle(1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 4'b0011, 32'd3, 32'd4, 1'b1);
    idle(1'b1);
    chk("unsup_err", {31'd0, rsp_err}, 32'd1);
    cycle(1'b1, 4'b0000, 32'hFF, 32'h0F, 1'b1, 4'b0010, 32'd1, 32'd1, 1'b1);
    cycle(1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 4'b0010, 32'd1, 32'd1, 1'b1);
    idle(1'b1);

    // slt back-to-back
    cycle(1'b1, 4'b0111, 32'd1, 32'd2, 1'b0, 4'd0, 32'd0, 32'd0, 1'b1);
    cycle(1'b1, 4'b0111, 32'd2, 32'd1, 1'b0, 4'd0, 32'd0, 32'd0, 1'b1);
    chk("slt_first", rsp_data, 32'd1);
    idle(1'b1);
    chk("slt_second", rsp_data, 32'd0);
    idle(1'b1);

    // Randomized traffic with hold-while-waiting requesters
    p0 = 1'b0; p1 = 1'b0;
    c0 = 4'd0; c1 = 4'd0; a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    for (int i = 0; i < 400; i++) begin
      if (!p0) begin
        v0 = ($urandom_range(0, 2) != 0);
        c0 = codes[$urandom_range(0, 7)];
        a0 = $urandom_range(0, 3) == 0 ? 32'($urandom_range(0, 3)) : $urandom;
        b0 = $urandom_range(0, 3) == 0 ? 32'($urandom_range(0, 3)) : $urandom;
      end
      if (!p1) begin
        v1 = ($urandom_range(0, 2) != 0);
        c1 = codes[$urandom_range(0, 7)];
        a1 = $urandom_range(0, 3) == 0 ? a0 : $urandom;
        b1 = $urandom_range(0, 3) == 0 ? a1 : $urandom;
      end
      rr = ($urandom_range(0, 3) != 0);
      cycle(v0, c0, a0, b0, v1, c1, a1, b1, rr);
      p0 = v0 && !last_acc0;
      p1 = v1 && !last_acc1;
    end
    idle(1'b1);
    idle(1'b1);

    // Async reset mid-stall after req0 moved prio to 1
    cycle(1'b1, 4'b0010, 32'd8, 32'd8, 1'b0, 4'd0, 32'd0, 32'd0, 1'b1);
    idle(1'b0);
    pulse_reset();
    cycle(1'b1, 4'b0001, 32'd1, 32'd2, 1'b1, 4'b0010, 32'd4, 32'd4, 1'b1);
    idle(1'b1);
    idle(1'b1);
    chk("queue_drained", q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single combinational 32-bit pipeline ALU between two requesters.
  - Requester 0: EX-stage issue.
  - Requester 1: auxiliary unit, e.g. address/branch-compare helper.
- Round-robin grant, valid/ready handshakes on every interface.
- Drives the ALU's in1/in2/control and captures out/zero into a one-entry registered response buffer tagged with the requester ID.
- Rejects control codes the ALU does not implement, so stale ALU output never propagates.

Parameters:
- WIDTH, 32: operand/result width; must match ALU width.
- PRIO_INIT, 0: requester that holds priority after reset (0 or 1).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req0_valid  input  1  requester 0 has an operation
- req0_ready  output  1  requester 0 operation accepted this cycle
- req0_ctrl  input  4  ALU control code for requester 0
- req0_a  input  WIDTH  operand 1 for requester 0
- req0_b  input  WIDTH  operand 2 for requester 0
- req1_valid, req1_ready, req1_ctrl, req1_a, req1_b: same as above, for requester 1
- alu_in1  output  WIDTH  to ALU in1
- alu_in2  output  WIDTH  to ALU in2
- alu_control  output  4  to ALU control
- alu_out  input  WIDTH  from ALU out (combinational)
- alu_zero  input  1  from ALU zero
- rsp_valid  output  1  response buffer holds a result
- rsp_ready  input  1  consumer takes response
- rsp_id  output  1  requester that issued the result
- rsp_data  output  WIDTH  result
- rsp_zero  output  1  result == 0
- rsp_err  output  1  control code was unsupported

Behaviour:
- Supported codes: 0000 and, 0001 or, 0010 add, 0110 sub, 0111 slt (unsigned compare as ALU implements), 1100 nor. All other codes are unsupported.
- can_accept = !rsp_valid || rsp_ready (buffer empty or draining this cycle).
- Grant, combinational:
  - Only one valid: that requester wins.
  - Both valid: the requester named by prio wins.
  - !can_accept: no grant.
  - reqN_ready = can_accept && grant==N. At most one ready is high per cycle. Readiness never depends on reqN_ready.
- ALU drive, combinational:
  - While granting: alu_in1/alu_in2/alu_control = the granted requester's a/b/ctrl.
  - Otherwise: 0/0/0010, so the ALU idles at an add of zeros.
- Capture at the clock edge of a handshake (valid && ready):
  - rsp_valid <= 1 and rsp_id <= grant.
  - Supported code: rsp_data <= alu_out, rsp_zero <= alu_zero, rsp_err <= 0.
  - Unsupported code: rsp_data <= 0, rsp_zero <= 1, rsp_err <= 1.
  - Latency is exactly 1 cycle from accept to rsp_valid.
- Drain: rsp_valid && rsp_ready with no new accept -> rsp_valid <= 0; the data fields hold their last values.
  - Simultaneous drain and accept -> the buffer is reloaded with rsp_valid staying 1. This gives back-to-back throughput of 1 per cycle.
- Stall: rsp_valid && !rsp_ready -> rsp_* fields are held stable, both readies are 0, and the ALU is driven to idle.
- Priority pointer prio:
  - On each accept, prio <= ~grant (the winner loses priority).
  - Unchanged otherwise.
  - A single persistent requester with the other idle is granted every cycle.
- Reset (rst_n low, async, any time including mid-stall):
  - rsp_valid=0, rsp_id=0, rsp_data=0, rsp_zero=0, rsp_err=0, prio=PRIO_INIT.
  - reqN_ready=0 while rst_n is low.
  - An accepted-but-undrained response is discarded.
- Requesters must hold a/b/ctrl stable while valid and not ready. The arbiter does not latch them before the handshake.
- No internal state beyond the response buffer and prio. An implementation with any additional pipeline stage is non-compliant.

Test Plan:
- Reset then single request: req0 ctrl=0010, a=5, b=7, rsp_ready=1 -> req0_ready=1 same cycle; next cycle rsp_valid=1, rsp_id=0, rsp_data=12, rsp_zero=0, rsp_err=0.
- Contention, PRIO_INIT=0:
  - Setup: both valid every cycle; req0 ctrl=0110, a=9, b=9; req1 ctrl=0001, a=0xF0, b=0x0F; rsp_ready=1.
  - Required: grants alternate 0,1,0,1.
  - Required responses: id0 data=0 zero=1; id1 data=0xFF zero=0.
- Backpressure:
  - Setup: rsp_ready=0 after the first accept (req1 ctrl=1100, a=b=0).
  - During the stall: rsp_data=0xFFFFFFFF held, both readies=0, alu_control=0010.
  - Raising rsp_ready -> same-cycle accept of the pending req0, and the buffer reloads without a bubble.
- Unsupported code: req1 ctrl=0011, a=3, b=4 -> rsp_valid=1, rsp_id=1, rsp_err=1, rsp_data=0, rsp_zero=1. prio still advances.
- slt and back-to-back: req0 streams ctrl=0111 with (1,2) then (2,1), rsp_ready=1 continuously -> rsp_data 1 then 0 on consecutive cycles, no idle cycle.
- Async reset mid-stall: response pending with rsp_ready=0; pulse rst_n low between clock edges -> rsp_valid drops immediately, all rsp_* are 0, prio=PRIO_INIT. The first post-reset request with both valid is granted to PRIO_INIT.
